// File: rtl/id_ex_shift_reg.sv
// ID/EX pipeline register for shift instructions: captures decoded fields, forwards rs/rt from
// EX/MEM and MEM/WB, and selects the shift amount for the EX-stage barrel shifter.
module id_ex_shift_reg #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [4:0]         id_rs_addr,
    input  logic [4:0]         id_rt_addr,
    input  logic [4:0]         id_rd_addr,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [SHAMT_W-1:0] id_shamt,
    input  logic               id_shift_var,
    input  logic [1:0]         id_shift_ft,
    input  logic               id_reg_write,
    input  logic               exmem_reg_write,
    input  logic [4:0]         exmem_rd_addr,
    input  logic [DATA_W-1:0]  exmem_result,
    input  logic               memwb_reg_write,
    input  logic [4:0]         memwb_rd_addr,
    input  logic [DATA_W-1:0]  memwb_result,
    output logic               ex_valid,
    output logic [SHAMT_W-1:0] ex_shift_a,
    output logic [DATA_W-1:0]  ex_shift_b,
    output logic [1:0]         ex_shift_ft,
    output logic [DATA_W-1:0]  ex_rs_fwd,
    output logic [4:0]         ex_rd_addr,
    output logic               ex_reg_write,
    output logic               ex_ft_illegal
);

    localparam logic [1:0] FT_SLL     = 2'b00;
    localparam logic [1:0] FT_ILLEGAL = 2'b10;

    logic               valid_q,      valid_d;
    logic [4:0]         rs_addr_q,    rs_addr_d;
    logic [4:0]         rt_addr_q,    rt_addr_d;
    logic [4:0]         rd_addr_q,    rd_addr_d;
    logic [DATA_W-1:0]  rs_data_q,    rs_data_d;
    logic [DATA_W-1:0]  rt_data_q,    rt_data_d;
    logic [SHAMT_W-1:0] shamt_q,      shamt_d;
    logic               shift_var_q,  shift_var_d;
    logic [1:0]         ft_q,         ft_d;
    logic               ft_illegal_q, ft_illegal_d;
    logic               reg_write_q,  reg_write_d;

    logic [DATA_W-1:0]  fwd_rs;
    logic [DATA_W-1:0]  fwd_rt;

    // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is hardwired and never forwarded.
    function automatic logic [DATA_W-1:0] forward(input logic [4:0]        addr,
                                                  input logic [DATA_W-1:0] reg_data);
        if (exmem_reg_write && exmem_rd_addr == addr && addr != 5'd0) begin
            return exmem_result;
        end else if (memwb_reg_write && memwb_rd_addr == addr && addr != 5'd0) begin
            return memwb_result;
        end
        return reg_data;
    endfunction

    always_comb begin
        fwd_rs = forward(rs_addr_q, rs_data_q);
        fwd_rt = forward(rt_addr_q, rt_data_q);
    end

    always_comb begin
        // NOTE: every _d gets a default before any branch, otherwise the unassigned paths infer latches.
        valid_d      = valid_q;
        rs_addr_d    = rs_addr_q;
        rt_addr_d    = rt_addr_q;
        rd_addr_d    = rd_addr_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        shamt_d      = shamt_q;
        shift_var_d  = shift_var_q;
        ft_d         = ft_q;
        ft_illegal_d = ft_illegal_q;
        reg_write_d  = reg_write_q;

        if (flush) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            ft_illegal_d = 1'b0;
        end else if (stall) begin
            // Refresh held operands so a producer retiring from MEM/WB mid-stall is not lost.
            rs_data_d = fwd_rs;
            rt_data_d = fwd_rt;
        end else begin
            valid_d      = id_valid;
            rs_addr_d    = id_rs_addr;
            rt_addr_d    = id_rt_addr;
            rd_addr_d    = id_rd_addr;
            rs_data_d    = id_rs_data;
            rt_data_d    = id_rt_data;
            shamt_d      = id_shamt;
            shift_var_d  = id_shift_var;
            reg_write_d  = id_reg_write;
            ft_d         = (id_shift_ft == FT_ILLEGAL) ? FT_SLL : id_shift_ft;
            ft_illegal_d = id_valid && (id_shift_ft == FT_ILLEGAL);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rd_addr_q    <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            shamt_q      <= '0;
            shift_var_q  <= 1'b0;
            ft_q         <= FT_SLL;
            ft_illegal_q <= 1'b0;
            reg_write_q  <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rs_addr_q    <= rs_addr_d;
            rt_addr_q    <= rt_addr_d;
            rd_addr_q    <= rd_addr_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            shamt_q      <= shamt_d;
            shift_var_q  <= shift_var_d;
            ft_q         <= ft_d;
            ft_illegal_q <= ft_illegal_d;
            reg_write_q  <= reg_write_d;
        end
    end

    always_comb begin
        ex_valid      = valid_q;
        ex_shift_a    = shift_var_q ? fwd_rs[SHAMT_W-1:0] : shamt_q;
        ex_shift_b    = fwd_rt;
        ex_shift_ft   = ft_q;
        ex_rs_fwd     = fwd_rs;
        ex_rd_addr    = rd_addr_q;
        ex_reg_write  = reg_write_q && valid_q;
        ex_ft_illegal = ft_illegal_q;
    end

endmodule
